// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 with SR/Cause/EPC/PRId, interrupt/exception arbitration and eret return address
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h0000_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  excCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);
  logic [5:0]  im, ip;
  logic        exl, ie, cbd;
  logic [4:0]  exc_code;
  logic [31:0] epc, sr, cause, pc_al;
  logic        int_pend, exc_pend;
  assign int_pend = |(HWInt & im) & ie & ~exl;
  assign exc_pend = (excCode != 5'd0) & ~exl;
  assign IntReq   = reset & (int_pend | exc_pend);
  assign pc_al    = PC & 32'hFFFF_FFFC;
  assign sr       = {16'd0, im, 8'd0, exl, ie};
  assign cause    = {cbd, 15'd0, ip, 3'd0, exc_code, 2'd0};
  assign EPCOut   = (WE && A2 == 5'd14 && !IntReq) ? {DIn[31:2], 2'b00} : epc;
  // mfc0 read mux straight from register state
  always_comb begin
    DOut = A1 == 5'd12 ? sr : A1 == 5'd13 ? cause : A1 == 5'd14 ? epc : A1 == 5'd15 ? PRID : 32'd0;
  end
  // exception entry beats mtc0/eret; an eret in the same cycle as mtc0 SR clears EXL after the write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im       <= '0;
      ip       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      cbd      <= 1'b0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= HWInt;
      if (IntReq) begin
        exl      <= 1'b1;
        exc_code <= int_pend ? 5'd0 : excCode;
        cbd      <= BD;
        epc      <= BD ? pc_al - 32'd4 : pc_al;
      end else begin
        if (WE && A2 == 5'd12) {im, exl, ie} <= {DIn[15:10], DIn[1], DIn[0]};
        if (WE && A2 == 5'd14) epc <= {DIn[31:2], 2'b00};
        if (EXLClr) exl <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed self-checking bench for cp0_unit
module tb_cp0_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  A1 = '0, A2 = '0, excCode = '0;
  logic [31:0] DIn = '0, PC = '0;
  logic        WE = 1'b0, BD = 1'b0, EXLClr = 1'b0;
  logic [5:0]  HWInt = '0;
  logic        IntReq;
  logic [31:0] EPCOut, DOut;
  int total = 0, passed = 0;

  cp0_unit #(.PRID(32'h0000_0007)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE), .PC(PC), .BD(BD),
    .excCode(excCode), .HWInt(HWInt), .EXLClr(EXLClr), .IntReq(IntReq), .EPCOut(EPCOut), .DOut(DOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    A1 = a;
    #1;
    chk(tag, DOut, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    WE = 0; A2 = 0; DIn = 0; excCode = 0; BD = 0; HWInt = 0; EXLClr = 0; PC = 0;
  endtask

  initial begin
    #2;
    chk("rst_intreq", {31'd0, IntReq}, 32'd0);
    rd("rst_sr", 5'd12, 32'd0);
    rd("rst_prid", 5'd15, 32'h0000_0007);
    #10 reset = 1'b1;
    tick();
    // 1: interrupt entry
    WE = 1; A2 = 12; DIn = 32'h0000_0401;
    tick();
    idle();
    rd("sr_write", 5'd12, 32'h0000_0401);
    HWInt = 6'b000001; PC = 32'h0000_3010;
    #1;
    chk("int_req", {31'd0, IntReq}, 32'd1);
    tick();
    idle();
    chk("int_req_after", {31'd0, IntReq}, 32'd0);
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr_exl", 5'd12, 32'h0000_0403);
    rd("int_epc", 5'd14, 32'h0000_3010);
    EXLClr = 1;
    tick();
    idle();
    rd("eret_sr", 5'd12, 32'h0000_0401);
    // 2: exception in delay slot
    excCode = 10; BD = 1; PC = 32'h0000_3008;
    #1;
    chk("exc_req", {31'd0, IntReq}, 32'd1);
    tick();
    idle();
    rd("exc_cause", 5'd13, 32'h8000_0028);
    rd("exc_epc", 5'd14, 32'h0000_3004);
    EXLClr = 1;
    tick();
    idle();
    // 3: interrupt + exception + ignored mtc0
    HWInt = 6'b000001; excCode = 12; PC = 32'h0000_3020; WE = 1; A2 = 12; DIn = 32'd0;
    #1;
    chk("both_req", {31'd0, IntReq}, 32'd1);
    chk("both_epcout", EPCOut, 32'h0000_3004);
    tick();
    idle();
    rd("both_cause", 5'd13, 32'h0000_0400);
    rd("both_sr", 5'd12, 32'h0000_0403);
    rd("both_epc", 5'd14, 32'h0000_3020);
    // 5a: EXL masks interrupts and exceptions
    HWInt = 6'b000001; excCode = 4;
    #1;
    chk("exl_mask", {31'd0, IntReq}, 32'd0);
    idle();
    // 4: eret with EPC bypass
    WE = 1; A2 = 14; DIn = 32'h0000_3047; EXLClr = 1;
    #1;
    chk("bypass", EPCOut, 32'h0000_3044);
    tick();
    idle();
    rd("ret_sr", 5'd12, 32'h0000_0401);
    rd("ret_epc", 5'd14, 32'h0000_3044);
    chk("ret_epcout", EPCOut, 32'h0000_3044);
    // 5b: IE=0 masks, reads, Cause not writable
    WE = 1; A2 = 12; DIn = 32'h0000_0400;
    tick();
    idle();
    HWInt = 6'b000001;
    #1;
    chk("ie_mask", {31'd0, IntReq}, 32'd0);
    HWInt = 0;
    rd("prid", 5'd15, 32'h0000_0007);
    rd("unmapped", 5'd3, 32'd0);
    WE = 1; A2 = 13; DIn = 32'hFFFF_FFFF;
    tick();
    idle();
    rd("cause_ro", 5'd13, 32'd0);
    // delay slot at PC=0 wraps
    WE = 1; A2 = 12; DIn = 32'h0000_0401;
    tick();
    idle();
    excCode = 5; BD = 1; PC = 32'd0;
    tick();
    idle();
    rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    rd("wrap_cause", 5'd13, 32'h8000_0014);
    // mtc0 SR together with eret: write lands, EXL forced clear
    WE = 1; A2 = 12; DIn = 32'h0000_0403; EXLClr = 1;
    tick();
    idle();
    rd("sr_eret", 5'd12, 32'h0000_0401);
    excCode = 12; PC = 32'h0000_3100;
    tick();
    idle();
    rd("pre_rst_epc", 5'd14, 32'h0000_3100);
    // 6: async reset mid-cycle
    #2 reset = 1'b0;
    HWInt = 6'b111111; excCode = 4;
    #1;
    chk("arst_intreq", {31'd0, IntReq}, 32'd0);
    rd("arst_sr", 5'd12, 32'd0);
    rd("arst_cause", 5'd13, 32'd0);
    rd("arst_epc", 5'd14, 32'd0);
    chk("arst_epcout", EPCOut, 32'd0);
    tick();
    chk("arst_hold_intreq", {31'd0, IntReq}, 32'd0);
    rd("arst_hold_cause", 5'd13, 32'd0);
    idle();
    #1 reset = 1'b1;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
